// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: FSM states, inverse S-box and
// GF(2^8) helpers used by the iterative decryption engine.
package aes_pkg;

  localparam int unsigned AES_NR = 10;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
      8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
      8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
      8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
      8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
      8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
      8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
      8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
      8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
      8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
      8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
      8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
      8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
      8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
      8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
      8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
      8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the low nibble is needed for the InvMixColumns constants.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  // Byte 4c+r sits at bits [127-8(4c+r) -: 8]; row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] shifted;
  logic [127:0] subbed;
  logic [127:0] added;
  logic [127:0] mixed;

  always_comb begin
    subbed  = '0;
    mixed   = '0;
    shifted = inv_shift_rows(state_in);
    for (int unsigned i = 0; i < 16; i++) begin
      subbed[127 - 8*i -: 8] = inv_sbox(shifted[127 - 8*i -: 8]);
    end
    added = subbed ^ rk;
    for (int unsigned c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = inv_mix_column(added[127 - 32*c -: 32]);
    end
    state_out = last ? added : mixed;
  end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher, one round per clock, round keys fetched
// by index from an external store with same-cycle response.
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
)
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   key_idx,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  fsm_t         fsm, fsm_next;
  logic [3:0]   round, round_next;
  logic [127:0] state, state_next;
  logic [127:0] round_out;
  logic         last;

  assign last = (fsm == FINAL);

  aes_inv_round_comb u_round (
    .state_in  (state),
    .rk        (round_key),
    .last      (last),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm   <= IDLE;
      round <= '0;
      state <= '0;
    end else begin
      fsm   <= fsm_next;
      round <= round_next;
      state <= state_next;
    end
  end

  // key_idx depends only on fsm/round so the key store never sees a loop.
  always_comb begin
    fsm_next   = fsm;
    round_next = round;
    state_next = state;
    key_idx    = 4'(NR);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = ~rst;
        key_idx  = 4'(NR);
        if (in_valid) begin
          state_next = in_block ^ round_key;
          round_next = 4'(NR - 1);
          fsm_next   = ROUND;
        end
      end
      ROUND: begin
        key_idx    = round;
        state_next = round_out;
        round_next = round - 4'd1;
        if (round == 4'd1) fsm_next = FINAL;
      end
      FINAL: begin
        key_idx    = '0;
        state_next = round_out;
        fsm_next   = DONE;
      end
      DONE: begin
        key_idx   = '0;
        out_valid = 1'b1;
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  assign out_block = state;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: forward AES model encrypts random plaintexts,
// the DUT must recover them with the documented cycle timing.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;

  logic [127:0] u_in;
  logic [127:0] u_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc = 0;

  logic [7:0]   sbox [256];
  logic [127:0] rks [11];
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_iter #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .key_idx   (key_idx),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  aes_inv_round_comb u_unit (
    .state_in  (u_in),
    .rk        (128'h0),
    .last      (1'b1),
    .state_out (u_out)
  );

  always_comb begin
    round_key = '0;
    if (key_idx <= 4'd10) round_key = rks[key_idx];
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- forward AES reference ----------------
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b};
    t = t << n;
    return t[15:8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) rks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] sub_all(input logic [127:0] x);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sbox[x[127 - 8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rks[0][127 - 8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
      for (int c = 0; c < 4; c++) begin
        if (rnd != 10) begin
          s[4*c]   = mul(t[4*c], 8'h02) ^ mul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ mul(t[4*c+1], 8'h02) ^ mul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ mul(t[4*c+2], 8'h02) ^ mul(t[4*c+3], 8'h03);
          s[4*c+3] = mul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ mul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c + r] = t[4*c + r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rks[rnd][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- cycle-level compare process ----------------
  // since: -1 idle, otherwise cycles elapsed after the accepting edge.
  int           since = -1;
  bit           fresh = 1'b0;
  logic [127:0] m_pt = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("in_ready_in_reset", 128'(in_ready), 128'd0);
      end else if (since < 0) begin
        chk("idle_in_ready", 128'(in_ready), 128'd1);
        chk("idle_key_idx", 128'(key_idx), 128'd10);
        chk("idle_out_valid", 128'(out_valid), 128'd0);
        if (fresh) chk("reset_out_block", out_block, 128'd0);
      end else if (since <= 9) begin
        chk("busy_in_ready", 128'(in_ready), 128'd0);
        chk("busy_out_valid", 128'(out_valid), 128'd0);
        chk("busy_key_idx", 128'(key_idx), (since <= 8) ? 128'(9 - since) : 128'd0);
      end else begin
        chk("done_out_valid", 128'(out_valid), 128'd1);
        chk("done_in_ready", 128'(in_ready), 128'd0);
        chk("done_key_idx", 128'(key_idx), 128'd0);
        chk("plaintext", out_block, m_pt);
      end
      if (rst) begin
        since = -1;
        fresh = 1'b1;
      end else if (since < 0) begin
        if (in_valid) begin
          since = 0;
          fresh = 1'b0;
          if (exp_q.size() > 0) m_pt = exp_q.pop_front();
          else begin
            checks++; errors++;
            $display("FAIL unexpected_accept got accept expected none (t=%0t)", $time);
          end
        end
      end else if (since >= 10) begin
        if (out_ready) since = -1;
      end else begin
        since++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    bit got = 1'b0;
    exp_q.push_back(pt);
    in_block = ct;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = in_ready;
    end
    chk("accept_within_budget", 128'(got), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_out();
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    chk("out_valid_within_budget", 128'(got), 128'd1);
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] k, pt, ct;
    int prev;
    rst = 1'b1;
    in_valid = 1'b0;
    in_block = '0;
    out_ready = 1'b1;
    u_in = '0;
    for (int j = 0; j < 11; j++) rks[j] = '0;

    build_sbox();
    chk("model_sbox_00", 128'(sbox[8'h00]), 128'h63);
    chk("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
    set_key(C1_KEY);
    chk("model_c1_rk10", rks[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_c1_encrypt", encrypt(C1_PT), C1_CT);
    set_key(B_KEY);
    chk("model_b_encrypt", encrypt(B_PT), B_CT);

    u_in = sub_all(128'h000102030405060708090a0b0c0d0e0f);
    #1;
    chk("unit_inv_shift", u_out, 128'h000d0a07_04010e0b_0805020f_0c090603);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // FIPS-197 C.1
    set_key(C1_KEY);
    send(C1_CT, C1_PT);
    wait_out();
    chk("c1_latency", 128'(cyc - acc), 128'd10);
    chk("c1_plaintext", out_block, C1_PT);
    @(posedge clk);
    #1;

    // FIPS-197 Appendix B
    set_key(B_KEY);
    send(B_CT, B_PT);
    wait_out();
    chk("b_plaintext", out_block, B_PT);
    @(posedge clk);
    #1;

    // Backpressure with ignored in_valid pulses while busy/done
    k = rand128();
    pt = rand128();
    set_key(k);
    ct = encrypt(pt);
    out_ready = 1'b0;
    send(ct, pt);
    wait_out();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i >= 5 && i < 9);
      in_block = rand128();
      @(negedge clk);
      chk("bp_out_block_stable", out_block, pt);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_in_ready_after_ack", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of a block
    set_key(C1_KEY);
    send(C1_CT, C1_PT);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        seen = (key_idx == 4'd6);
      end
      chk("reach_round6", 128'(seen), 128'd1);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_out_valid", 128'(out_valid), 128'd0);
    chk("mid_reset_out_block", out_block, 128'd0);
    chk("mid_reset_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    send(C1_CT, C1_PT);
    wait_out();
    chk("c1_after_reset", out_block, C1_PT);
    @(posedge clk);
    #1;

    // Back-to-back random blocks
    prev = -1;
    for (int n = 0; n < 96; n++) begin
      k = rand128();
      pt = rand128();
      set_key(k);
      ct = encrypt(pt);
      send(ct, pt);
      if (prev >= 0) chk("b2b_spacing", 128'(acc - prev), 128'd12);
      prev = acc;
      wait_out();
      @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES-128 inverse cipher: accepts a 128-bit ciphertext block and produces the plaintext, one round per clock. It is the decryption counterpart to the forward shiftRow/AES_core datapath. It sits beside the encryption core and shares the external round-key store, which it addresses by key index. Valid/ready handshakes are used on both input and output.

Parameters:
NR, 10, number of rounds (AES-128 only; other values unsupported)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_block valid
in_ready  output  1  engine can accept a block
in_block  input  128  ciphertext; [127:120] = byte 0, column-major (byte 4c+r = state[r][c])
key_idx  output  4  round-key index requested this cycle
round_key  input  128  round key for key_idx, combinational same-cycle response
out_valid  output  1  out_block holds plaintext
out_ready  input  1  consumer accepts out_block
out_block  output  128  plaintext, same byte ordering as in_block

Behaviour:
- Reset (rst high at a clock edge): FSM goes to IDLE, round counter = 0, state register = 0, out_valid = 0, out_block = 0. in_ready = 0 while rst is high.
- Reset mid-operation: the block in flight is discarded. No out_valid is produced for it.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready = 1, key_idx = 10.
  - On in_valid & in_ready: state <= in_block ^ round_key, round <= 9, go to ROUND.
  - Otherwise stay in IDLE.
- ROUND:
  - key_idx = round.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key), round <= round - 1.
  - If round == 1, go to FINAL; else stay in ROUND.
- FINAL:
  - key_idx = 0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ round_key.
  - Go to DONE.
- DONE:
  - out_valid = 1, out_block = state, key_idx = 0, in_ready = 0.
  - On out_ready, go to IDLE. Otherwise hold out_block stable indefinitely.
- Latency: if a block is accepted at edge k, out_valid rises after edge k+10.
- Handshake and throughput:
  - Minimum 12 cycles per block; no overlap of input and output.
  - in_valid asserted outside IDLE is ignored; the source must hold it until in_ready.
- Datapath definitions:
  - InvShiftRows: row r rotates right by r, i.e. out[r][c] = in[r][(c-r) mod 4].
  - InvSubBytes: FIPS-197 inverse S-box per byte.
  - InvMixColumns: GF(2^8) multiply by the matrix {0e,0b,0d,09} circulant, reduction polynomial 0x11b.
- key_idx is a pure function of FSM state and round counter: no combinational path from round_key, no path from out_ready to in_ready.
- Simultaneous out_ready and a pending in_valid in DONE: the output is accepted and the FSM returns to IDLE. The input is accepted on the next cycle.

Decomposition:
- Package aes_pkg holds:
  - AES_NR = 10.
  - FSM state enum.
  - Inverse S-box function (256-entry case).
  - xtime / gf_mul helper functions.
  - inv_mix_column function (32-bit column).
  - inv_shift_rows function.
- One combinational sub-module, aes_inv_round_comb:
  - Inputs: state_in[127:0], rk[127:0], last.
  - Output: state_out[127:0].
  - InvMixColumns is bypassed when last = 1.
  - It is unit-tested separately.
- The FSM, counter and handshake stay in aes_inv_cipher_iter.

Test Plan:
- Inverse-shift unit test on aes_inv_round_comb's shift stage: 000102030405060708090a0b0c0d0e0f -> 000d0a07_04010e0b_0805020f_0c090603.
- FIPS-197 C.1: bench key model expands key 000102...0f; ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> out_block 00112233445566778899aabbccddeeff, out_valid exactly 10 cycles after acceptance, key_idx sequence 10,9,...,1,0.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c; ciphertext 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> out_block stable, in_ready = 0 throughout; in_valid pulsed during busy is ignored; out_ready high -> in_ready = 1 the next cycle.
- Reset mid-operation: assert rst at round 5 for 1 cycle -> next cycle out_valid = 0, out_block = 0, in_ready = 1; a new C.1 block then decrypts correctly.
- Back-to-back random: 96 random key/ciphertext pairs from a software model, out_ready held high -> all plaintexts match, error count 0, 12 cycles per block.
